// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program loader: FSM states, frame sync byte, header field layout.
// Pure definitions; no logic, no latency, no backpressure.
package program_loader_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Header byte layout: {start_addr, count_m1}
  localparam int HDR_ADDR_MSB = 7;
  localparam int HDR_ADDR_LSB = 4;
  localparam int HDR_CNT_MSB  = 3;
  localparam int HDR_CNT_LSB  = 0;

  function automatic logic [3:0] hdr_start_addr(input logic [7:0] hdr);
    return hdr[HDR_ADDR_MSB:HDR_ADDR_LSB];
  endfunction

  function automatic logic [3:0] hdr_count_m1(input logic [7:0] hdr);
    return hdr[HDR_CNT_MSB:HDR_CNT_LSB];
  endfunction

endpackage

// File: rtl/prog_mem.sv
// Program memory: one synchronous write port, one asynchronous read port; not reset.
// Write visible on rd_data the cycle after the write edge (old value during it); never stalls.
module prog_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/program_loader.sv
// Receives SYNC/header/data/checksum frames and writes the data bytes into program memory.
// One byte per cycle when in_ready; in_ready drops only for the single DONE cycle.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             run_en
);

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q;
  logic [3:0]    remaining_q;
  logic [7:0]    sum_q;
  logic          loaded_q;
  logic          error_q;

  logic          accept;
  logic          wr_en;
  logic [7:0]    sum_plus_in;

  assign accept      = in_valid && in_ready;
  assign sum_plus_in = sum_q + in_data;

  always_comb begin
    state_d  = state_q;
    in_ready = (state_q != DONE);
    busy     = (state_q != IDLE);
    done     = (state_q == DONE);
    wr_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && in_data == SYNC_BYTE) begin
          state_d = HDR;
        end
      end
      HDR: begin
        if (accept) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (accept) begin
          wr_en = 1'b1;
          if (remaining_q == 4'd0) begin
            state_d = CSUM;
          end
        end
      end
      CSUM: begin
        if (accept) begin
          state_d = (sum_plus_in == 8'h00) ? DONE : IDLE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      remaining_q <= '0;
      sum_q       <= '0;
      loaded_q    <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        case (state_q)
          IDLE: begin
            if (in_data == SYNC_BYTE) begin
              loaded_q <= 1'b0;
              error_q  <= 1'b0;
            end
          end
          HDR: begin
            ptr_q       <= AW'(hdr_start_addr(in_data));
            remaining_q <= hdr_count_m1(in_data);
            sum_q       <= in_data;
          end
          DATA: begin
            sum_q <= sum_plus_in;
            ptr_q <= ptr_q + 1'b1;
            if (remaining_q != 4'd0) begin
              remaining_q <= remaining_q - 4'd1;
            end
          end
          CSUM: begin
            sum_q <= sum_plus_in;
            if (sum_plus_in == 8'h00) begin
              loaded_q <= 1'b1;
            end else begin
              error_q <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign error  = error_q;
  assign run_en = loaded_q && !busy;

  // Partial frames leave their writes in place: memory has no reset or rollback.
  prog_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_prog_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (ptr_q),
    .wr_data (WIDTH'(in_data)),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_program_loader.sv
// Table-driven frame tests with a memory-expectation scoreboard, plus hand sequences for corner cases.
module tb_program_loader;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       busy;
  logic       done;
  logic       error;
  logic       run_en;

  int passed = 0;
  int total  = 0;

  program_loader dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .run_en   (run_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] frame;   // bytes left-aligned, first byte in [63:56]
    int          nb;
    logic        exp_done;
    logic        exp_err;
    logic        exp_run;
    logic [11:0] ea;      // expected addresses, left-aligned nibbles
    logic [23:0] ed;      // expected data, left-aligned bytes
    int          ne;
  } vec_t;

  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
  } mem_exp_t;

  mem_exp_t sb[$];
  vec_t     vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h want %0h", name, act, exp);
    else passed++;
  endtask

  // Drives one byte and returns #1 after the edge that accepted it.
  task automatic send_byte(input logic [7:0] b);
    int budget;
    budget = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && budget < 20) begin
      @(posedge clk);
      #1;
      budget++;
    end
    if (!in_ready) begin
      total++;
      $display("FAIL send_timeout: byte %0h never accepted", b);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic push_exp(input logic [3:0] a, input logic [7:0] d);
    mem_exp_t e;
    e.a = a;
    e.d = d;
    sb.push_back(e);
  endtask

  task automatic drain_sb(input string tag);
    mem_exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd_addr = e.a;
      #1;
      check($sformatf("%s_mem%0h", tag, e.a), {24'd0, rd_data}, {24'd0, e.d});
    end
  endtask

  initial begin
    vecs[0] = '{64'hA5_02_05_43_80_36_00_00, 6, 1'b1, 1'b0, 1'b1, 12'h012, 24'h05_43_80, 3};
    vecs[1] = '{64'hA5_F1_11_22_DC_00_00_00, 5, 1'b1, 1'b0, 1'b1, 12'hF00, 24'h11_22_00, 2};
    vecs[2] = '{64'hA5_00_07_00_00_00_00_00, 4, 1'b0, 1'b1, 1'b0, 12'h000, 24'h07_00_00, 1};
    vecs[3] = '{64'hA5_01_A5_10_4A_00_00_00, 5, 1'b1, 1'b0, 1'b1, 12'h010, 24'hA5_10_00, 2};
    vecs[4] = '{64'hA5_32_01_02_03_C8_00_00, 6, 1'b1, 1'b0, 1'b1, 12'h345, 24'h01_02_03, 3};
    vecs[5] = '{64'h3C_FF_A5_00_09_F7_00_00, 6, 1'b1, 1'b0, 1'b1, 12'h000, 24'h09_00_00, 1};

    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    rd_addr  = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    check("rst_busy",     {31'd0, busy},     32'd0);
    check("rst_done",     {31'd0, done},     32'd0);
    check("rst_error",    {31'd0, error},    32'd0);
    check("rst_run_en",   {31'd0, run_en},   32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < vecs[v].ne; k++)
        push_exp(vecs[v].ea[11-4*k -: 4], vecs[v].ed[23-8*k -: 8]);
      for (int i = 0; i < vecs[v].nb; i++)
        send_byte(vecs[v].frame[63-8*i -: 8]);
      check($sformatf("v%0d_done", v),  {31'd0, done},  {31'd0, vecs[v].exp_done});
      check($sformatf("v%0d_error", v), {31'd0, error}, {31'd0, vecs[v].exp_err});
      @(posedge clk);
      #1;
      check($sformatf("v%0d_done_off", v), {31'd0, done},   32'd0);
      check($sformatf("v%0d_busy", v),     {31'd0, busy},   32'd0);
      check($sformatf("v%0d_run_en", v),   {31'd0, run_en}, {31'd0, vecs[v].exp_run});
      drain_sb($sformatf("v%0d", v));
    end

    // in_valid held high straight through DONE into the next frame
    push_exp(4'h0, 8'h0A);
    send_byte(8'hA5); in_valid = 1'b1;
    send_byte(8'h00); in_valid = 1'b1;
    send_byte(8'h09); in_valid = 1'b1;
    send_byte(8'hF7); in_valid = 1'b1;
    in_data = 8'hA5;
    check("hold_done",     {31'd0, done},     32'd1);
    check("hold_in_ready", {31'd0, in_ready}, 32'd0);
    send_byte(8'hA5); in_valid = 1'b1;
    check("hold_busy_hdr", {31'd0, busy},     32'd1);
    send_byte(8'h00); in_valid = 1'b1;
    send_byte(8'h0A); in_valid = 1'b1;
    send_byte(8'hF6);
    check("hold_done2",    {31'd0, done},     32'd1);
    @(posedge clk);
    #1;
    check("hold_run_en",   {31'd0, run_en},   32'd1);
    drain_sb("hold");

    // Read-during-write shows old value, new value the following cycle
    send_byte(8'hA5);
    send_byte(8'h30);
    rd_addr  = 4'h3;
    in_valid = 1'b1;
    in_data  = 8'h77;
    #1;
    check("rdw_old", {24'd0, rd_data}, 32'h01);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("rdw_new", {24'd0, rd_data}, 32'h77);
    send_byte(8'h59);
    check("rdw_done", {31'd0, done}, 32'd1);
    @(posedge clk);
    #1;

    // Reset mid-frame keeps partial writes
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h55);
    check("midrst_busy_pre", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midrst_busy",   {31'd0, busy},   32'd0);
    check("midrst_run_en", {31'd0, run_en}, 32'd0);
    push_exp(4'h0, 8'h55);
    drain_sb("midrst");
    push_exp(4'h1, 8'h66);
    push_exp(4'h2, 8'h77);
    push_exp(4'h0, 8'h55);
    send_byte(8'hA5);
    send_byte(8'h11);
    send_byte(8'h66);
    send_byte(8'h77);
    send_byte(8'h12);
    check("postrst_done", {31'd0, done}, 32'd1);
    @(posedge clk);
    #1;
    check("postrst_run_en", {31'd0, run_en}, 32'd1);
    drain_sb("postrst");

    // Reset wins over a simultaneous SYNC handshake
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    check("rstprio_busy",   {31'd0, busy},   32'd0);
    check("rstprio_run_en", {31'd0, run_en}, 32'd0);
    check("rstprio_error",  {31'd0, error},  32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter DEPTH, default 16: number of program-memory words; addresses are 4 bits wide.
REQ-002 Parameter WIDTH, default 8: program-memory word width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: in_data holds a byte offered for loading.
REQ-006 The block SHALL have port in_data, input, 8 bits: the offered byte.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the loader can accept a byte this cycle.
REQ-008 The block SHALL have port rd_addr, input, 4 bits: the CPU fetch address.
REQ-009 The block SHALL have port rd_data, output, 8 bits: mem[rd_addr], combinational read.
REQ-010 The block SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse on frame success.
REQ-012 The block SHALL have port error, output, 1 bit: sticky flag for the last frame's checksum failure.
REQ-013 The block SHALL have port run_en, output, 1 bit: the CPU may execute; equals loaded && !busy.

Function
REQ-014 A byte SHALL be accepted only in a cycle where in_valid && in_ready are both high.
REQ-015 The frame format SHALL be: SYNC byte 0xA5; header {start_addr[7:4], count_m1[3:0]}; count_m1+1 data bytes; checksum byte.
REQ-016 The FSM states SHALL be IDLE, HDR, DATA, CSUM and DONE.
REQ-017 In IDLE, an accepted byte equal to 0xA5 SHALL move the FSM to HDR, set busy, and clear loaded and error; any other accepted byte SHALL be discarded.
REQ-018 In HDR, an accepted byte SHALL latch the write pointer (=start_addr) and the remaining count (=count_m1), seed the running sum with the header byte, and move the FSM to DATA.
REQ-019 In DATA, each accepted byte SHALL be written to mem[ptr] in the same clock edge, add to the sum mod 256, and advance ptr by one mod 16 (15 -> 0 wraps).
REQ-020 In DATA, the accepted byte that arrives with remaining==0 SHALL move the FSM to CSUM; otherwise remaining decrements.
REQ-021 In CSUM, the accepted byte SHALL be added to the sum; if the total mod 256 is 0x00, the FSM SHALL go to DONE and set loaded; otherwise it SHALL go to IDLE and set error.
REQ-022 A checksum failure SHALL NOT undo memory writes already made by that frame.
REQ-023 DONE SHALL last exactly one cycle: done=1 and in_ready=0, then the FSM returns to IDLE.
REQ-024 in_ready SHALL be 1 in every state except DONE.
REQ-025 busy SHALL be 1 in HDR, DATA, CSUM and DONE, and 0 in IDLE.
REQ-026 A write SHALL be visible on rd_data from the cycle after the accepting edge.
REQ-027 When rd_addr equals the address being written, rd_data SHALL show the old value during the writing cycle.
REQ-028 A 0xA5 byte received in HDR, DATA or CSUM SHALL be treated as ordinary data, not as a resync.

Reset
REQ-029 On reset, the FSM SHALL go to IDLE with busy=0, done=0, error=0, loaded=0 (so run_en=0), ptr=0, remaining=0 and sum=0.
REQ-030 Reset SHALL NOT clear program memory; a frame interrupted by reset leaves its partial writes in place.
REQ-031 When reset is asserted, it SHALL take priority over any simultaneous in_valid handshake.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, the SYNC_BYTE = 8'hA5 constant, and the header field positions.
REQ-033 The 16x8 memory with one write port and one asynchronous read port SHALL be a sub-module named prog_mem; the FSM, pointer and checksum logic SHALL live in program_loader.

Verification
REQ-034 Frame A5,02,05,43,80,36 -> mem[0..2]=05,43,80; done pulses 1 cycle after the 0x36 byte; run_en=1; error=0.
REQ-035 Wrap frame A5,F1,11,22,DC -> mem[15]=11, mem[0]=22; done=1.
REQ-036 Frame A5,00,07,00 (bad checksum) -> mem[0]=07; error=1; loaded=0; run_en=0. A subsequent valid frame -> error=0, run_en=1.
REQ-037 Bytes 3C,FF before A5,00,09,F7 -> leading bytes discarded; mem[0]=09; done=1. in_valid held high through DONE -> in_ready=0 for that cycle and no byte is lost.
REQ-038 reset asserted after A5,01,55 -> busy=0, run_en=0, mem[0]=55 retained; next full frame loads normally.
